// File: rtl/conv_same_seq_if.sv
// Config and memory/MAC handshake bundle for conv_same_seq.
// mode exists only when CONV_FULL_MODE_EN is defined.
interface conv_same_seq_if;
  logic       start;
  logic [4:0] size_x;
  logic [4:0] size_y;
`ifdef CONV_FULL_MODE_EN
  logic       mode;
`endif
  logic       rd_en;
  logic [4:0] addr_x;
  logic [4:0] addr_y;
  logic       acc_ld;
  logic       acc_en;
  logic       wr_en;
  logic [5:0] addr_z;
  logic       busy;
  logic       done;

  modport master (
`ifdef CONV_FULL_MODE_EN
    output mode,
`endif
    output start, size_x, size_y,
    input  rd_en, addr_x, addr_y, acc_ld, acc_en, wr_en, addr_z, busy, done
  );

  modport slave (
`ifdef CONV_FULL_MODE_EN
    input  mode,
`endif
    input  start, size_x, size_y,
    output rd_en, addr_x, addr_y, acc_ld, acc_en, wr_en, addr_z, busy, done
  );
endinterface

// File: rtl/conv_same_seq.sv
// Address/control sequencer for a 1-D "same" convolution (one tap per cycle).
// Define CONV_FULL_MODE_EN to add a latched mode bit selecting full convolution.
module conv_same_seq #(
  parameter int unsigned MEM_LAT = 1
) (
  input logic            clk_i,
  input logic            rst_n_i,
  conv_same_seq_if.slave bus
);

  localparam int unsigned SW = 9;  // per-stage {en, ld, last, n[5:0]}
  localparam int unsigned PW = SW * MEM_LAT;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StFin} state_e;

  state_e     state_q, state_d;
  logic [4:0] nx_q, nx_d, ny_q, ny_d;
  logic [5:0] n_q, n_d, last_n_q, last_n_d;
  logic [6:0] m_q, m_d, k_q, k_d, kmin_q, kmin_d, kmax_q, kmax_d;
  logic [2:0] cnt_q, cnt_d;
  logic       busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [4:0] addr_x_q, addr_x_d, addr_y_q, addr_y_d;
  logic       wr_en_q;
  logic [5:0] addr_z_q;
  logic [PW-1:0] pipe_q;
  logic [SW-1:0] stage_in, stage_out;
  logic [6:0] c_w, m_new, lo_w, hi_w;
`ifdef CONV_FULL_MODE_EN
  logic       mode_q, mode_d;
`endif

  // Lowest k whose sample index m-k still lies inside x.
  function automatic logic [6:0] lo_tap(input logic [6:0] m, input logic [4:0] nx);
    logic [6:0] top;
    top = {2'b00, nx} - 7'd1;
    return (m > top) ? m - top : 7'd0;
  endfunction

  function automatic logic [6:0] hi_tap(input logic [6:0] m, input logic [4:0] ny);
    logic [6:0] top;
    top = {2'b00, ny} - 7'd1;
    return (m < top) ? m : top;
  endfunction

`ifdef CONV_FULL_MODE_EN
  assign c_w = mode_q ? 7'd0 : (({2'b00, ny_q} - 7'd1) >> 1);
`else
  assign c_w = ({2'b00, ny_q} - 7'd1) >> 1;
`endif
  assign m_new = (state_q == StLoad) ? c_w : m_q + 7'd1;
  assign lo_w  = lo_tap(m_new, nx_q);
  assign hi_w  = hi_tap(m_new, ny_q);

  always_comb begin
    state_d  = state_q;
    nx_d     = nx_q;
    ny_d     = ny_q;
    n_d      = n_q;
    last_n_d = last_n_q;
    m_d      = m_q;
    k_d      = k_q;
    kmin_d   = kmin_q;
    kmax_d   = kmax_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    rd_en_d  = rd_en_q;
    done_d   = 1'b0;
`ifdef CONV_FULL_MODE_EN
    mode_d   = mode_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          nx_d   = bus.size_x;
          ny_d   = bus.size_y;
          busy_d = 1'b1;
`ifdef CONV_FULL_MODE_EN
          mode_d = bus.mode;
`endif
          state_d = (bus.size_x == 5'd0 || bus.size_y == 5'd0) ? StFin : StLoad;
        end
      end
      StLoad: begin
        n_d      = 6'd0;
        m_d      = m_new;
        kmin_d   = lo_w;
        kmax_d   = hi_w;
        k_d      = lo_w;
        rd_en_d  = 1'b1;
        last_n_d = {1'b0, nx_q} - 6'd1;
`ifdef CONV_FULL_MODE_EN
        if (mode_q) last_n_d = {1'b0, nx_q} + {1'b0, ny_q} - 6'd2;
`endif
        state_d  = StRun;
      end
      StRun: begin
        if (k_q == kmax_q) begin
          if (n_q == last_n_q) begin
            rd_en_d = 1'b0;
            cnt_d   = 3'd0;
            state_d = StDrain;
          end else begin
            // Next output's first tap follows immediately.
            n_d    = n_q + 6'd1;
            m_d    = m_new;
            kmin_d = lo_w;
            kmax_d = hi_w;
            k_d    = lo_w;
          end
        end else begin
          k_d = k_q + 7'd1;
        end
      end
      StDrain: begin
        if (cnt_q == 3'(MEM_LAT - 1)) state_d = StFin;
        else cnt_d = cnt_q + 3'd1;
      end
      StFin: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    addr_x_d = 5'(m_d - k_d);
    addr_y_d = k_d[4:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      nx_q     <= '0;
      ny_q     <= '0;
      n_q      <= '0;
      last_n_q <= '0;
      m_q      <= '0;
      k_q      <= '0;
      kmin_q   <= '0;
      kmax_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_x_q <= '0;
      addr_y_q <= '0;
`ifdef CONV_FULL_MODE_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      nx_q     <= nx_d;
      ny_q     <= ny_d;
      n_q      <= n_d;
      last_n_q <= last_n_d;
      m_q      <= m_d;
      k_q      <= k_d;
      kmin_q   <= kmin_d;
      kmax_q   <= kmax_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      addr_x_q <= addr_x_d;
      addr_y_q <= addr_y_d;
`ifdef CONV_FULL_MODE_EN
      mode_q   <= mode_d;
`endif
    end
  end

  // Tap tags travel alongside the memory read so they meet the data at the MAC.
  assign stage_in  = {rd_en_q, rd_en_q & (k_q == kmin_q), rd_en_q & (k_q == kmax_q), n_q};
  assign stage_out = pipe_q[PW-1 -: SW];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pipe_q   <= '0;
      wr_en_q  <= 1'b0;
      addr_z_q <= '0;
    end else begin
      pipe_q  <= PW'({pipe_q, stage_in});
      wr_en_q <= stage_out[8] & stage_out[6];
      if (stage_out[8] && stage_out[6]) addr_z_q <= stage_out[5:0];
    end
  end

  assign bus.rd_en  = rd_en_q;
  assign bus.addr_x = addr_x_q;
  assign bus.addr_y = addr_y_q;
  assign bus.acc_en = stage_out[8];
  assign bus.acc_ld = stage_out[7];
  assign bus.wr_en  = wr_en_q;
  assign bus.addr_z = addr_z_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_conv_same_seq.sv
// Scoreboard bench for conv_same_seq: a tap-enumeration model queues expected strobes,
// a negedge monitor pops and compares them.
module tb_conv_same_seq;
  localparam int unsigned MEM_LAT = 1;
  localparam int L = MEM_LAT;
  localparam int Budget = 3000;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  conv_same_seq_if bus();

  conv_same_seq #(.MEM_LAT(MEM_LAT)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int t; int a; int b;} ev_t;
  ev_t rd_q[$];
  ev_t acc_q[$];
  ev_t wr_q[$];
  ev_t done_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got strobe expected none (cycle %0d)", name, cyc);
  endtask

  task automatic flush();
    rd_q.delete();
    acc_q.delete();
    wr_q.delete();
    done_q.delete();
  endtask

  // Monitor: every strobe the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (bus.rd_en) begin
        if (rd_q.size() == 0) unexp("rd_extra");
        else begin
          e = rd_q.pop_front();
          chk("rd_cycle", cyc, e.t);
          chk("rd_addr_x", int'(bus.addr_x), e.a);
          chk("rd_addr_y", int'(bus.addr_y), e.b);
        end
      end
      if (bus.acc_en) begin
        if (acc_q.size() == 0) unexp("acc_extra");
        else begin
          e = acc_q.pop_front();
          chk("acc_cycle", cyc, e.t);
          chk("acc_ld", int'(bus.acc_ld), e.a);
        end
      end else if (bus.acc_ld) begin
        unexp("acc_ld_without_en");
      end
      if (bus.wr_en) begin
        if (wr_q.size() == 0) unexp("wr_extra");
        else begin
          e = wr_q.pop_front();
          chk("wr_cycle", cyc, e.t);
          chk("wr_addr_z", int'(bus.addr_z), e.a);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) unexp("done_extra");
        else begin
          e = done_q.pop_front();
          chk("done_cycle", cyc, e.t);
          chk("busy_at_done", int'(bus.busy), 0);
        end
      end
    end
  end

  // Enumerates every (n, k) pair with a valid sample index; cycle 0 is the start cycle.
  task automatic issue(input int nx, input int ny, input int md);
    int t0, c, cnt, t, last_t, i;
    bit first;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.size_x = 5'(nx);
    bus.size_y = 5'(ny);
`ifdef CONV_FULL_MODE_EN
    bus.mode   = md[0];
`endif
    t0 = cyc;
    if (nx == 0 || ny == 0) begin
      done_q.push_back('{t0 + 2, 0, 0});
    end else begin
      c   = (md != 0) ? 0 : (ny - 1) / 2;
      cnt = (md != 0) ? nx + ny - 1 : nx;
      t   = 0;
      for (int n = 0; n < cnt; n++) begin
        first  = 1'b1;
        last_t = 0;
        for (int k = 0; k < ny; k++) begin
          i = n + c - k;
          if (i >= 0 && i < nx) begin
            rd_q.push_back('{t0 + 2 + t, i, k});
            acc_q.push_back('{t0 + 2 + t + L, first ? 1 : 0, 0});
            first  = 1'b0;
            last_t = t;
            t++;
          end
        end
        wr_q.push_back('{t0 + 2 + last_t + L + 1, n, 0});
      end
      done_q.push_back('{t0 + t + L + 3, 0, 0});
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus.size_x = 5'($urandom);
    bus.size_y = 5'($urandom);
`ifdef CONV_FULL_MODE_EN
    bus.mode   = 1'($urandom);
`endif
    chk("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((rd_q.size() + acc_q.size() + wr_q.size() + done_q.size()) != 0 && w < Budget) begin
      @(posedge clk);
      w++;
    end
    chk("run_completes", (w < Budget) ? 1 : 0, 1);
    if (w >= Budget) flush();
    @(negedge clk);
    chk("busy_idle", int'(bus.busy), 0);
  endtask

  task automatic run(input int nx, input int ny, input int md);
    issue(nx, ny, md);
    wait_idle();
  endtask

  initial begin
    int nx, ny, md;
    rst_n      = 1'b1;
    bus.start  = 1'b0;
    bus.size_x = '0;
    bus.size_y = '0;
`ifdef CONV_FULL_MODE_EN
    bus.mode   = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #2;
    chk("rst_rd_en", int'(bus.rd_en), 0);
    chk("rst_acc_en", int'(bus.acc_en), 0);
    chk("rst_acc_ld", int'(bus.acc_ld), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_addr_x", int'(bus.addr_x), 0);
    chk("rst_addr_y", int'(bus.addr_y), 0);
    chk("rst_addr_z", int'(bus.addr_z), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(4, 3, 0);
    run(1, 1, 0);
    run(5, 4, 0);
    run(0, 3, 0);
    run(3, 0, 0);
    run(31, 31, 0);
    run(31, 1, 0);
    run(1, 31, 0);
`ifdef CONV_FULL_MODE_EN
    run(2, 2, 1);
    run(31, 31, 1);
`endif

    for (int r = 0; r < 25; r++) begin
      nx = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
      ny = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
      md = 0;
`ifdef CONV_FULL_MODE_EN
      md = int'($urandom_range(0, 1));
`endif
      run(nx, ny, md);
    end

    // Reset in the middle of RUN must drop every strobe at once.
    issue(20, 9, 0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rd_en", int'(bus.rd_en), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_acc_en", int'(bus.acc_en), 0);
    chk("midrst_addr_x", int'(bus.addr_x), 0);
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_after_reset", int'(bus.busy), 0);

    // A start pulse while busy must not restart or add taps.
    issue(6, 5, 0);
    repeat (3) @(negedge clk);
    bus.start  = 1'b1;
    bus.size_x = 5'd3;
    bus.size_y = 5'd2;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_idle();
    run(2, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
